// File: rtl/apu_note_sequencer.sv
// apu_note_sequencer
//
// Playback controller for the APU note path. On a play request it walks note
// memory from start_addr up to (not including) end_addr, one word per note
// period, and hands each word to the tone datapath as a one-cycle note_valid
// strobe. Note timing freezes while codec_ready_i is low. Playback can loop,
// and dropping play_i aborts it at any point.
//
// Ports:
//   clk_i          single clock
//   reset_i        synchronous, active-high reset
//   start_addr_i   first address played (sampled on start)
//   end_addr_i     exclusive end address (sampled on start)
//   loop_i         sampled at each end of range; 1 = restart at start address
//   play_i         level play request; deassertion aborts
//   codec_ready_i  codec configured; 0 freezes the note divider
//   mem_addr_o     note memory read address (1-cycle synchronous read)
//   mem_rdata_i    word at the previous cycle's mem_addr_o
//   note_o         current note, holds between strobes, 0 = rest
//   note_valid_o   one-cycle strobe, note_o updated in the same cycle
//   playing_o      high while fetching, latching or waiting
//   done_o         one-cycle pulse at the end of a non-looping pass or empty range
//
// state | meaning
// IDLE  | waiting for play with codec ready
// FETCH | memory read in flight
// LATCH | present the read word as a note strobe
// WAIT  | note period divider running
// HOLD  | pass finished, waiting for play to drop
module apu_note_sequencer #(
  parameter logic [31:0] MAIN_CLK_SPEED = 32'd50_000_000,
  parameter logic [31:0] NOTE_CLK_SPEED = 32'd16,
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned NOTE_W         = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [ADDR_W-1:0] end_addr_i,
  input  logic              loop_i,
  input  logic              play_i,
  input  logic              codec_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [NOTE_W-1:0] mem_rdata_i,
  output logic [NOTE_W-1:0] note_o,
  output logic              note_valid_o,
  output logic              playing_o,
  output logic              done_o
);

  localparam logic [31:0] TICK     = MAIN_CLK_SPEED / NOTE_CLK_SPEED;
  // Divider value at which the next fetch is launched, giving a period of
  // 1 LATCH + (TICK-2) WAIT + 1 FETCH cycles.
  localparam logic [31:0] DIV_NEXT = TICK - 32'd3;
  // The closing rest lands one cycle later, so done trails the last strobe
  // by TICK-1 cycles.
  localparam logic [31:0] DIV_LAST = TICK - 32'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] s_q, s_d;
  logic [ADDR_W-1:0] e_q, e_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic              note_valid_q, note_valid_d;
  logic              playing_q, playing_d;
  logic              done_q, done_d;
  logic [31:0]       div_q, div_d;
  logic [ADDR_W-1:0] next_addr;
  logic              active;

  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    s_d          = s_q;
    e_d          = e_q;
    note_d       = note_q;
    note_valid_d = 1'b0;
    done_d       = 1'b0;
    div_d        = div_q;
    next_addr    = mem_addr_q + ADDR_W'(1);
    active       = (state_q == S_FETCH) || (state_q == S_LATCH) || (state_q == S_WAIT);

    case (state_q)
      S_IDLE: begin
        if (play_i && codec_ready_i) begin
          s_d = start_addr_i;
          e_d = end_addr_i;
          if (start_addr_i < end_addr_i) begin
            mem_addr_d = start_addr_i;
            state_d    = S_FETCH;
          end else begin
            done_d  = 1'b1;
            state_d = S_HOLD;
          end
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        note_d       = mem_rdata_i;
        note_valid_d = 1'b1;
        div_d        = '0;
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        if (codec_ready_i) begin
          if (div_q == DIV_LAST) begin
            // Only reachable after a non-looping end of range.
            done_d  = 1'b1;
            note_d  = '0;
            state_d = S_HOLD;
          end else if (div_q == DIV_NEXT && next_addr != e_q) begin
            mem_addr_d = next_addr;
            state_d    = S_FETCH;
          end else if (div_q == DIV_NEXT && loop_i) begin
            mem_addr_d = s_q;
            state_d    = S_FETCH;
          end else begin
            div_d = div_q + 32'd1;
          end
        end
      end
      S_HOLD: begin
        if (!play_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over every other transition out of an active state.
    if (active && !play_i) begin
      state_d      = S_IDLE;
      mem_addr_d   = mem_addr_q;
      note_d       = '0;
      note_valid_d = 1'b0;
      done_d       = 1'b0;
    end

    playing_d = (state_d == S_FETCH) || (state_d == S_LATCH) || (state_d == S_WAIT);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      mem_addr_q   <= '0;
      s_q          <= '0;
      e_q          <= '0;
      note_q       <= '0;
      note_valid_q <= 1'b0;
      playing_q    <= 1'b0;
      done_q       <= 1'b0;
      div_q        <= '0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      s_q          <= s_d;
      e_q          <= e_d;
      note_q       <= note_d;
      note_valid_q <= note_valid_d;
      playing_q    <= playing_d;
      done_q       <= done_d;
      div_q        <= div_d;
    end
  end

  assign mem_addr_o   = mem_addr_q;
  assign note_o       = note_q;
  assign note_valid_o = note_valid_q;
  assign playing_o    = playing_q;
  assign done_o       = done_q;

endmodule
